mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the number of REQ-state cycles without bus_ack before a bus error (range 1..255).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port m_wreg  in  1  M-stage register-write enable.
REQ-005 SHALL have port m_m2reg  in  1  M-stage load (writeback from memory).
REQ-006 SHALL have port m_wmem  in  1  M-stage store.
REQ-007 SHALL have port m_rn  in  5  M-stage destination register.
REQ-008 SHALL have port m_aluout  in  32  M-stage effective address / ALU result.
REQ-009 SHALL have port m_data  in  32  M-stage store data.
REQ-010 SHALL have port bus_ack  in  1  data-bus completion, sampled only in REQ.
REQ-011 SHALL have port bus_rdata  in  32  data-bus read data, valid with bus_ack.
REQ-012 SHALL have port mem_stall  out  1  combinational stall to the M pipeline registers (m_stall) and all earlier stages.
REQ-013 SHALL have port bus_req  out  1  registered bus request.
REQ-014 SHALL have port bus_we  out  1  registered write strobe (1 = store).
REQ-015 SHALL have port bus_addr  out  32  registered word address, {m_aluout[31:2],2'b00}.
REQ-016 SHALL have port bus_wdata  out  32  registered store data.
REQ-017 SHALL have port w_wreg  out  1  W-stage register-write enable.
REQ-018 SHALL have port w_m2reg  out  1  W-stage select of w_mdata.
REQ-019 SHALL have port w_rn  out  5  W-stage destination register.
REQ-020 SHALL have port w_aluout  out  32  W-stage ALU result.
REQ-021 SHALL have port w_mdata  out  32  W-stage load data.
REQ-022 SHALL have port exc_align  out  1  one-cycle misaligned-access pulse.
REQ-023 SHALL have port exc_bus  out  1  one-cycle bus-timeout pulse.

Function
REQ-024 SHALL implement states IDLE, REQ, DONE; access = m_m2reg | m_wmem; if both are set, store SHALL take precedence and no load data SHALL be written back.
REQ-025 IDLE: aligned access (m_aluout[1:0]==0) SHALL assert mem_stall and move to REQ, loading bus_req=1, bus_we=m_wmem, bus_addr, and bus_wdata at that edge; all other inputs SHALL leave the state in IDLE with mem_stall=0.
REQ-026 REQ: mem_stall=1; timeout counter SHALL increment each cycle; bus_ack=1 SHALL capture bus_rdata into an internal load register, clear bus_req, clear the counter, and move to DONE.
REQ-027 REQ: counter reaching TIMEOUT with bus_ack=0 SHALL clear bus_req, set a pending bus-error flag, and move to DONE; bus_ack in the same cycle as the timeout SHALL win (no error).
REQ-028 DONE: mem_stall=0; next edge SHALL return to IDLE; bus_ack in IDLE or DONE SHALL be ignored.
REQ-029 W registers SHALL load every edge where mem_stall=0: w_rn, w_aluout, and w_mdata (load register) from the M stage; w_m2reg=m_m2reg&~m_wmem; w_wreg=m_wreg, forced to 0 on misalignment or pending bus error.
REQ-030 Whenever mem_stall=1, W registers SHALL load a bubble (w_wreg=0, w_m2reg=0), so each instruction is written back exactly once.
REQ-031 Misaligned access in IDLE SHALL issue no bus request, keep mem_stall=0, suppress w_wreg, and pulse exc_align for the following cycle.
REQ-032 exc_bus SHALL pulse for exactly the cycle after DONE that ended a timeout.
REQ-033 Minimum aligned-access latency SHALL be 3 cycles (IDLE, REQ with ack, DONE); a non-memory instruction SHALL pass with 0 stall cycles.

Reset
REQ-034 resetn=0 SHALL immediately force IDLE, clear the counter and error flag, and drive every output to 0, including mid-REQ, where bus_req SHALL drop without waiting for bus_ack.

Verification
REQ-035 Load at 0x100, bus_ack in the first REQ cycle, rdata=0xDEADBEEF -> mem_stall high 2 cycles; w_wreg=1, w_m2reg=1, w_mdata=0xDEADBEEF once.
REQ-036 Store 0x12345678 to 0x204 with ack after 4 REQ cycles -> bus_we=1, bus_addr=0x204, bus_wdata=0x12345678; mem_stall high 5 cycles; w_wreg bubble during the stall.
REQ-037 Load at 0x102 -> bus_req stays 0, mem_stall=0, exc_align one cycle, w_wreg=0.
REQ-038 TIMEOUT=4, no ack -> bus_req drops after 4 REQ cycles, then exc_bus pulses once and w_wreg=0; an ack in the 4th cycle instead -> normal completion, no exc_bus.
REQ-039 resetn pulsed low during REQ -> bus_req=0 asynchronously; the next access starts cleanly from IDLE.
REQ-040 Back-to-back ALU, load, ALU -> ALU instructions write back with no stall; the load stalls 2 cycles; ordering preserved.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-access controller for the M pipeline stage: issues one data-bus
// transaction per aligned load/store, stalls the pipeline until it completes
// (or times out), and drives the W-stage pipeline registers.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m_wreg,
  input  logic        m_m2reg,
  input  logic        m_wmem,
  input  logic [4:0]  m_rn,
  input  logic [31:0] m_aluout,
  input  logic [31:0] m_data,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        w_wreg,
  output logic        w_m2reg,
  output logic [4:0]  w_rn,
  output logic [31:0] w_aluout,
  output logic [31:0] w_mdata,
  output logic        exc_align,
  output logic        exc_bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT);

  state_t      state;
  logic [7:0]  cnt;
  logic        err_pend;
  logic [31:0] load_reg;

  logic access;
  logic aligned;
  logic misalign;

  assign access   = m_m2reg | m_wmem;
  assign aligned  = (m_aluout[1:0] == 2'b00);
  assign misalign = access & ~aligned;

  // Stall while an aligned access is being launched or is in flight; held low in reset.
  always_comb begin
    mem_stall = 1'b0;
    case (state)
      IDLE:    mem_stall = access & aligned;
      REQ:     mem_stall = 1'b1;
      DONE:    mem_stall = 1'b0;
      default: mem_stall = 1'b0;
    endcase
    mem_stall = mem_stall & resetn;
  end

  // Access FSM with registered bus outputs, timeout counter and exception pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      err_pend  <= 1'b0;
      load_reg  <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      exc_align <= 1'b0;
      exc_bus   <= 1'b0;
    end else begin
      exc_align <= 1'b0;
      exc_bus   <= 1'b0;
      case (state)
        IDLE: begin
          if (access && aligned) begin
            state     <= REQ;
            bus_req   <= 1'b1;
            bus_we    <= m_wmem;
            bus_addr  <= {m_aluout[31:2], 2'b00};
            bus_wdata <= m_data;
            cnt       <= '0;
          end else if (misalign) begin
            exc_align <= 1'b1;
          end
        end
        REQ: begin
          // An ack arriving on the timeout cycle still completes normally.
          if (bus_ack) begin
            load_reg <= bus_rdata;
            bus_req  <= 1'b0;
            cnt      <= '0;
            state    <= DONE;
          end else if (cnt + 8'd1 == TO_LAST) begin
            bus_req  <= 1'b0;
            err_pend <= 1'b1;
            cnt      <= '0;
            state    <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          exc_bus  <= err_pend;
          err_pend <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // W-stage registers: advance when not stalled, insert a bubble while stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_wreg   <= 1'b0;
      w_m2reg  <= 1'b0;
      w_rn     <= '0;
      w_aluout <= '0;
      w_mdata  <= '0;
    end else if (mem_stall) begin
      w_wreg  <= 1'b0;
      w_m2reg <= 1'b0;
    end else begin
      w_wreg   <= m_wreg & ~misalign & ~err_pend;
      w_m2reg  <= m_m2reg & ~m_wmem;
      w_rn     <= m_rn;
      w_aluout <= m_aluout;
      w_mdata  <= load_reg;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with TIMEOUT=4.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m_wreg, m_m2reg, m_wmem;
  logic [4:0]  m_rn;
  logic [31:0] m_aluout, m_data;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        mem_stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        w_wreg, w_m2reg;
  logic [4:0]  w_rn;
  logic [31:0] w_aluout, w_mdata;
  logic        exc_align, exc_bus;

  int vectors = 0;
  int errors  = 0;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn),
    .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_wmem(m_wmem), .m_rn(m_rn),
    .m_aluout(m_aluout), .m_data(m_data),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .mem_stall(mem_stall), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .w_wreg(w_wreg), .w_m2reg(w_m2reg), .w_rn(w_rn),
    .w_aluout(w_aluout), .w_mdata(w_mdata),
    .exc_align(exc_align), .exc_bus(exc_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_m(input logic wreg, input logic m2reg, input logic wmem,
                       input logic [4:0] rn, input logic [31:0] alu, input logic [31:0] dat);
    m_wreg = wreg; m_m2reg = m2reg; m_wmem = wmem;
    m_rn = rn; m_aluout = alu; m_data = dat;
  endtask

  // Holds the current M instruction until the stall clears; acks on REQ cycle ack_at (0 = never).
  // Returns at a negedge with mem_stall low; the next posedge retires the instruction.
  task automatic do_access(input int ack_at, output int stalls, output int reqcyc,
                           output logic we, output logic [31:0] addr, output logic [31:0] wd,
                           output logic bubble_bad);
    bit done = 0;
    stalls = 0; reqcyc = 0; we = 0; addr = '0; wd = '0; bubble_bad = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (!mem_stall) begin
        bus_ack = 1'b0;
        done = 1;
      end else begin
        stalls++;
        if (bus_req) begin
          reqcyc++;
          we = bus_we; addr = bus_addr; wd = bus_wdata;
          if (w_wreg) bubble_bad = 1;
        end
        bus_ack = bus_req && (reqcyc == ack_at);
        @(negedge clk);
      end
    end
    if (!done) begin
      chk("stall_bound", 32'(stalls), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $fatal(1, "stall never cleared");
    end
  endtask

  int stalls, reqcyc;
  logic we_s, bub;
  logic [31:0] addr_s, wd_s;

  initial begin
    resetn = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    set_m(1, 1, 0, 5'd1, 32'h40, 32'h0);
    #1;
    chk("rst_stall", 32'(mem_stall), 32'd0);
    @(negedge clk);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_wreg", 32'(w_wreg), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_exc", {30'd0, exc_align, exc_bus}, 32'd0);
    set_m(0, 0, 0, 5'd0, 32'h0, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Aligned load, ack in first REQ cycle
    set_m(1, 1, 0, 5'd3, 32'h100, 32'h0);
    bus_rdata = 32'hDEADBEEF;
    do_access(1, stalls, reqcyc, we_s, addr_s, wd_s, bub);
    chk("ld_stalls", 32'(stalls), 32'd2);
    chk("ld_addr", addr_s, 32'h100);
    chk("ld_we", 32'(we_s), 32'd0);
    @(negedge clk);
    chk("ld_wreg", 32'(w_wreg), 32'd1);
    chk("ld_m2reg", 32'(w_m2reg), 32'd1);
    chk("ld_mdata", w_mdata, 32'hDEADBEEF);
    chk("ld_rn", 32'(w_rn), 32'd3);
    set_m(0, 0, 0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    chk("ld_once", 32'(w_wreg), 32'd0);

    // Store, ack in 4th REQ cycle (also the timeout cycle: ack wins)
    set_m(0, 0, 1, 5'd0, 32'h204, 32'h12345678);
    do_access(4, stalls, reqcyc, we_s, addr_s, wd_s, bub);
    chk("st_stalls", 32'(stalls), 32'd5);
    chk("st_reqcyc", 32'(reqcyc), 32'd4);
    chk("st_we", 32'(we_s), 32'd1);
    chk("st_addr", addr_s, 32'h204);
    chk("st_wdata", wd_s, 32'h12345678);
    @(negedge clk);
    chk("st_wreg", 32'(w_wreg), 32'd0);
    chk("st_excbus", 32'(exc_bus), 32'd0);

    // Misaligned load
    set_m(1, 1, 0, 5'd4, 32'h102, 32'h0);
    do_access(1, stalls, reqcyc, we_s, addr_s, wd_s, bub);
    chk("mis_stalls", 32'(stalls), 32'd0);
    @(negedge clk);
    chk("mis_req", 32'(bus_req), 32'd0);
    chk("mis_wreg", 32'(w_wreg), 32'd0);
    chk("mis_exc", 32'(exc_align), 32'd1);
    set_m(0, 0, 0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    chk("mis_exc_end", 32'(exc_align), 32'd0);

    // Timeout: no ack
    set_m(1, 1, 0, 5'd8, 32'h300, 32'h0);
    do_access(0, stalls, reqcyc, we_s, addr_s, wd_s, bub);
    chk("to_reqcyc", 32'(reqcyc), 32'd4);
    chk("to_stalls", 32'(stalls), 32'd5);
    chk("to_req_low", 32'(bus_req), 32'd0);
    chk("to_exc_early", 32'(exc_bus), 32'd0);
    @(negedge clk);
    chk("to_exc", 32'(exc_bus), 32'd1);
    chk("to_wreg", 32'(w_wreg), 32'd0);
    set_m(0, 0, 0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    chk("to_exc_end", 32'(exc_bus), 32'd0);

    // Ack exactly on the timeout cycle for a load
    set_m(1, 1, 0, 5'd9, 32'h308, 32'h0);
    bus_rdata = 32'hCAFEF00D;
    do_access(4, stalls, reqcyc, we_s, addr_s, wd_s, bub);
    @(negedge clk);
    chk("ack4_exc", 32'(exc_bus), 32'd0);
    chk("ack4_wreg", 32'(w_wreg), 32'd1);
    chk("ack4_mdata", w_mdata, 32'hCAFEF00D);

    // Reset asserted mid-REQ
    set_m(1, 1, 0, 5'd10, 32'h400, 32'h0);
    #1;
    chk("rr_stall", 32'(mem_stall), 32'd1);
    @(negedge clk);
    chk("rr_req", 32'(bus_req), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rr_req_drop", 32'(bus_req), 32'd0);
    chk("rr_stall_drop", 32'(mem_stall), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    bus_rdata = 32'h0BADF00D;
    do_access(2, stalls, reqcyc, we_s, addr_s, wd_s, bub);
    chk("rr_stalls", 32'(stalls), 32'd3);
    chk("rr_addr", addr_s, 32'h400);
    @(negedge clk);
    chk("rr_mdata", w_mdata, 32'h0BADF00D);
    chk("rr_wreg", 32'(w_wreg), 32'd1);

    // ALU, load, ALU back to back
    set_m(1, 0, 0, 5'd5, 32'h11, 32'h0);
    do_access(1, stalls, reqcyc, we_s, addr_s, wd_s, bub);
    chk("alu1_stalls", 32'(stalls), 32'd0);
    @(negedge clk);
    chk("alu1_rn", 32'(w_rn), 32'd5);
    chk("alu1_res", w_aluout, 32'h11);
    chk("alu1_wm", {30'd0, w_wreg, w_m2reg}, 32'd2);
    set_m(1, 1, 0, 5'd6, 32'h500, 32'h0);
    bus_rdata = 32'h000055AA;
    do_access(1, stalls, reqcyc, we_s, addr_s, wd_s, bub);
    chk("ld2_stalls", 32'(stalls), 32'd2);
    chk("ld2_bubble", 32'(bub), 32'd0);
    @(negedge clk);
    chk("ld2_rn", 32'(w_rn), 32'd6);
    chk("ld2_mdata", w_mdata, 32'h000055AA);
    chk("ld2_wm", {30'd0, w_wreg, w_m2reg}, 32'd3);
    set_m(1, 0, 0, 5'd7, 32'h22, 32'h0);
    do_access(1, stalls, reqcyc, we_s, addr_s, wd_s, bub);
    chk("alu2_stalls", 32'(stalls), 32'd0);
    @(negedge clk);
    chk("alu2_rn", 32'(w_rn), 32'd7);
    chk("alu2_wm", {30'd0, w_wreg, w_m2reg}, 32'd2);

    // Load and store both set: store wins, no load writeback select
    set_m(1, 1, 1, 5'd12, 32'h600, 32'hA5A5A5A5);
    do_access(1, stalls, reqcyc, we_s, addr_s, wd_s, bub);
    chk("both_we", 32'(we_s), 32'd1);
    chk("both_wdata", wd_s, 32'hA5A5A5A5);
    @(negedge clk);
    chk("both_m2reg", 32'(w_m2reg), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
